// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the system clock.
// Pixel enable, position counters, registered syncs/bright, frame ticks.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC_END  = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC_END  = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        vblank_tick,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  if (CLK_DIV < 1 || CLK_DIV > 16 ||
      !(H_SYNC_END < H_VIS_START) ||
      !(H_VIS_START < H_VIS_END) ||
      !(H_VIS_END <= H_TOTAL) || H_TOTAL > 1024 ||
      !(V_SYNC_END < V_VIS_START) ||
      !(V_VIS_START < V_VIS_END) ||
      !(V_VIS_END <= V_TOTAL) || V_TOTAL > 1024)
  begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HSE     = 11'(H_SYNC_END);
  localparam logic [10:0] HVS     = 11'(H_VIS_START);
  localparam logic [10:0] HVE     = 11'(H_VIS_END);
  localparam logic [10:0] VSE     = 11'(V_SYNC_END);
  localparam logic [10:0] VVS     = 11'(V_VIS_START);
  localparam logic [10:0] VVE     = 11'(V_VIS_END);

  logic [3:0]  div_q, div_d;
  logic        pix_q, pix_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        br_q, br_d;
  logic        vbl_q, vbl_d;
  logic        ft_q, ft_d;
  logic [15:0] fc_q, fc_d;
  logic [10:0] hx, vx;

  // Next-state: divider, counters, and decodes of the next position
  always_comb begin
    div_d = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
    pix_d = (div_d == DIV_MAX);
    h_d   = h_q;
    v_d   = v_q;
    if (pix_q) begin
      if (h_q == H_MAX) begin
        h_d = 10'd0;
        v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hx    = {1'b0, h_d};
    vx    = {1'b0, v_d};
    hs_d  = !(hx < HSE);
    vs_d  = !(vx < VSE);
    br_d  = (hx >= HVS) && (hx < HVE) &&
            (vx >= VVS) && (vx < VVE);
    ft_d  = pix_q && (h_q == H_MAX) && (v_q == V_MAX);
    vbl_d = pix_q && (h_d == 10'd0) && (vx == VVE);
    fc_d  = fc_q + 16'd1;
  end

  // Timing state register; reset parks at (0,0) inside both syncs
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 4'd0;
      pix_q <= 1'b0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      br_q  <= 1'b0;
      vbl_q <= 1'b0;
      ft_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      pix_q <= pix_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      br_q  <= br_d;
      vbl_q <= vbl_d;
      ft_q  <= ft_d;
    end
  end

  // Completed-frame counter, advances only on the frame wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q <= 16'd0;
    end else if (ft_d) begin
      fc_q <= fc_d;
    end
  end

  assign pix_en      = pix_q;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign bright      = br_q;
  assign vblank_tick = vbl_q;
  assign frame_tick  = ft_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks raster timing against a pixel-index model.
// Small timing parameters keep a frame at 960 clocks.
module tb_vga_timing_gen;

  localparam int D   = 4;
  localparam int HT  = 20;
  localparam int HSE = 3;
  localparam int HVS = 5;
  localparam int HVE = 17;
  localparam int VT  = 12;
  localparam int VSE = 2;
  localparam int VVS = 4;
  localparam int VVE = 10;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        vblank_tick;
  logic        frame_tick;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC_END(HSE),
    .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC_END(VSE),
    .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hCount(hCount), .vCount(vCount),
    .hSync(hSync), .vSync(vSync), .bright(bright),
    .vblank_tick(vblank_tick), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: n = clocks since reset release, P = pixel advances so far
  int          n = 0;
  int          P = 0;
  bit          adv = 1'b0;
  logic [15:0] base = 16'd0;

  function automatic bit exp_pix(int k);
    return (k >= 1) && (k % D == D - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n = 0; P = 0; adv = 1'b0; base = 16'd0;
    end else begin
      adv = exp_pix(n);
      if (adv) P++;
      n++;
    end
  end

  // Per-cycle compare against the model, sampled after the edge
  always @(posedge clk) begin
    int h, v;
    #1;
    if (chk_en) begin
      h = P % HT;
      v = (P / HT) % VT;
      chk("pix_en", 32'(pix_en), 32'(exp_pix(n)));
      chk("hCount", 32'(hCount), 32'(h));
      chk("vCount", 32'(vCount), 32'(v));
      chk("hSync", 32'(hSync), 32'(!(h < HSE)));
      chk("vSync", 32'(vSync), 32'(!(v < VSE)));
      chk("bright", 32'(bright),
          32'(h >= HVS && h < HVE && v >= VVS && v < VVE));
      chk("frame_tick", 32'(frame_tick), 32'(adv && (P % FR == 0)));
      chk("vblank_tick", 32'(vblank_tick),
          32'(adv && (P % FR == VVE * HT)));
      chk("frame_count", 32'(frame_count), 32'(16'(base + 16'(P / FR))));
    end
  end

  task automatic wait_hv(int h, int v, int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (hCount == 10'(h) && vCount == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    int   ft_k, vb_k;
    logic b0, b1, b2, b3;

    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_h", 32'(hCount), 32'd0);
    chk("rst_hs", 32'(hSync), 32'd0);
    chk("rst_vs", 32'(vSync), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    reset = 1'b0;

    repeat (3) @(negedge clk);
    chk("first_pix", 32'(pix_en), 32'd1);
    chk("h_before", 32'(hCount), 32'd0);
    @(negedge clk);
    chk("h_after", 32'(hCount), 32'd1);
    chk("pix_off", 32'(pix_en), 32'd0);

    wait_hv(10, 6, 2000, ok);
    chk("mid_found", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_h", 32'(hCount), 32'd0);
    chk("mid_v", 32'(vCount), 32'd0);
    chk("mid_br", 32'(bright), 32'd0);
    chk("mid_fc", 32'(frame_count), 32'd0);
    chk("mid_ft", 32'(frame_tick), 32'd0);
    reset = 1'b0;

    ft_k = -1; vb_k = -1;
    b0 = 1'bx; b1 = 1'bx; b2 = 1'bx; b3 = 1'bx;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (vblank_tick && vb_k < 0) vb_k = k;
      if (vCount == 10'(VVS)) begin
        if (hCount == 10'(HVS - 1)) b0 = bright;
        if (hCount == 10'(HVS))     b1 = bright;
        if (hCount == 10'(HVE - 1)) b2 = bright;
        if (hCount == 10'(HVE))     b3 = bright;
      end
      if (frame_tick) begin
        ft_k = k;
        break;
      end
    end
    chk("ft1_clk", 32'(ft_k), 32'd960);
    chk("vb1_clk", 32'(vb_k), 32'd800);
    chk("ft1_fc", 32'(frame_count), 32'd1);
    chk("ft1_hv", 32'({hCount, vCount}), 32'd0);
    chk("br_pre", 32'(b0), 32'd0);
    chk("br_first", 32'(b1), 32'd1);
    chk("br_last", 32'(b2), 32'd1);
    chk("br_post", 32'(b3), 32'd0);

    ft_k = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        ft_k = k;
        break;
      end
    end
    chk("ft2_gap", 32'(ft_k), 32'd960);
    chk("ft2_fc", 32'(frame_count), 32'd2);

    wait_hv(10, 3, 2000, ok);
    chk("force_found", 32'(ok), 32'd1);
    force dut.fc_q = 16'hFFFF;
    base = 16'hFFFF - 16'(P / FR);
    @(negedge clk);
    release dut.fc_q;
    ft_k = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        ft_k = k;
        break;
      end
    end
    chk("wrap_seen", 32'(ft_k > 0), 32'd1);
    chk("wrap_fc", 32'(frame_count), 32'd0);

    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
